// File: rtl/rx_fifo.sv
//==============================================================================
// rx_fifo - 16550-style receive FIFO with per-character status | rev 1.0
//==============================================================================
`default_nettype none

module rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic [1:0]    trig_lvl,
   input  logic          push,
   input  logic [7:0]    din,
   input  logic          pe_in,
   input  logic          fe_in,
   input  logic          bi_in,
   input  logic          pop,
   input  logic          lsr_rd,
   output logic [7:0]    dout,
   output logic          pe_out,
   output logic          fe_out,
   output logic          bi_out,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          trig,
   output logic          overrun,
   output logic          err_in_fifo
);

   localparam logic [AW:0]   FULL_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   logic [10:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   cnt;
   logic [AW:0]   err_cnt;
   logic          ovr;
   logic          en_q;

   logic [AW:0]   eff_depth;
   logic [4:0]    trig_level;
   logic [10:0]   head;
   logic          flush;
   logic          pop_ok;
   logic          push_ok;
   logic          drop;
   logic          push_err;
   logic          pop_err;

   // In 16450 mode the FIFO degenerates to a single holding register.
   always_comb begin
      eff_depth = en ? FULL_DEPTH : CNT_ONE;
      case (trig_lvl)
         2'b00:   trig_level = 5'd1;
         2'b01:   trig_level = 5'd4;
         2'b10:   trig_level = 5'd8;
         default: trig_level = 5'd14;
      endcase
      if (!en) trig_level = 5'd1;
   end

   assign head     = mem[rptr];
   assign flush    = clr | (en ^ en_q);
   assign pop_ok   = pop & (cnt != '0);
   // A push into a full FIFO still fits when a pop frees a slot in the same cycle.
   assign push_ok  = push & ((cnt < eff_depth) | pop_ok);
   assign drop     = push & ~push_ok & ~flush;
   assign push_err = push_ok & (pe_in | fe_in | bi_in);
   assign pop_err  = pop_ok & (|head[10:8]);

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wptr] <= {bi_in, fe_in, pe_in, din};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         cnt     <= '0;
         err_cnt <= '0;
         ovr     <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         en_q <= en;
         if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            err_cnt <= '0;
         end else begin
            if (push_ok) wptr <= wptr + PTR_ONE;
            if (pop_ok)  rptr <= rptr + PTR_ONE;
            case ({push_ok, pop_ok})
               2'b10:   cnt <= cnt + CNT_ONE;
               2'b01:   cnt <= cnt - CNT_ONE;
               default: cnt <= cnt;
            endcase
            case ({push_err, pop_err})
               2'b10:   err_cnt <= err_cnt + CNT_ONE;
               2'b01:   err_cnt <= err_cnt - CNT_ONE;
               default: err_cnt <= err_cnt;
            endcase
         end
         if (drop)        ovr <= 1'b1;
         else if (lsr_rd) ovr <= 1'b0;
      end
   end

   // Masking while empty keeps the head outputs known before any write.
   assign {bi_out, fe_out, pe_out, dout} = empty ? 11'd0 : head;
   assign empty       = (cnt == '0);
   assign full        = (cnt == eff_depth);
   assign count       = cnt;
   assign trig        = int'(cnt) >= int'(trig_level);
   assign overrun     = ovr;
   assign err_in_fifo = (err_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo.sv
//==============================================================================
// tb_rx_fifo - self-checking bench for rx_fifo | rev 1.0
//==============================================================================
`default_nettype none

module tb_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic          clr = 1'b0;
   logic [1:0]    trig_lvl = 2'b00;
   logic          push = 1'b0;
   logic [7:0]    din = 8'h00;
   logic          pe_in = 1'b0;
   logic          fe_in = 1'b0;
   logic          bi_in = 1'b0;
   logic          pop = 1'b0;
   logic          lsr_rd = 1'b0;
   logic [7:0]    dout;
   logic          pe_out;
   logic          fe_out;
   logic          bi_out;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          trig;
   logic          overrun;
   logic          err_in_fifo;

   always #5 clk = ~clk;

   rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .trig_lvl(trig_lvl),
      .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in),
      .pop(pop), .lsr_rd(lsr_rd), .dout(dout), .pe_out(pe_out),
      .fe_out(fe_out), .bi_out(bi_out), .empty(empty), .full(full),
      .count(count), .trig(trig), .overrun(overrun), .err_in_fifo(err_in_fifo)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [10:0] sb[$];
   logic        m_ovr = 1'b0;
   logic        m_en  = 1'b0;

   typedef struct {
      logic       push;
      logic [7:0] din;
      logic [2:0] errs;
      logic       pop;
      logic       clr;
      logic       lsr;
      logic [4:0] e_count;
      logic       e_empty;
      logic       e_trig;
      logic       e_err;
      logic       e_ovr;
      logic       chk_d;
      logic [7:0] e_dout;
      logic       e_pe;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int level(input logic e, input logic [1:0] t);
      if (!e) return 1;
      case (t)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 14;
      endcase
   endfunction

   task automatic check_state();
      int depth = en ? DEPTH : 1;
      int nerr = 0;
      foreach (sb[i]) if (|sb[i][10:8]) nerr++;
      chk("count", 32'(count), 32'(sb.size()));
      chk("empty", 32'(empty), 32'(sb.size() == 0));
      chk("full", 32'(full), 32'(sb.size() == depth));
      chk("trig", 32'(trig), 32'(sb.size() >= level(en, trig_lvl)));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("err_in_fifo", 32'(err_in_fifo), 32'(nerr != 0));
      if (sb.size() > 0) chk("head", 32'({bi_out, fe_out, pe_out, dout}), 32'(sb[0]));
   endtask

   // Drives one cycle of strobes, updates the reference model and checks flags after the edge.
   task automatic step(input logic p, input logic [7:0] d, input logic [2:0] errs,
                       input logic po, input logic c, input logic l);
      int   sz    = sb.size();
      int   depth = en ? DEPTH : 1;
      logic flush;
      logic pop_ok  = 1'b0;
      logic push_ok = 1'b0;
      logic drop    = 1'b0;
      push = p; din = d; {bi_in, fe_in, pe_in} = errs; pop = po; clr = c; lsr_rd = l;
      #1;
      flush = c || (en != m_en);
      if (flush) begin
         sb.delete();
      end else begin
         pop_ok  = po && (sz > 0);
         push_ok = p && ((sz < depth) || pop_ok);
         drop    = p && !push_ok;
         if (pop_ok) begin
            chk("pop_head", 32'({bi_out, fe_out, pe_out, dout}), 32'(sb[0]));
            sb.delete(0);
         end
         if (push_ok) sb.push_back({errs, d});
      end
      if (drop)   m_ovr = 1'b1;
      else if (l) m_ovr = 1'b0;
      m_en = en;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; clr = 1'b0; lsr_rd = 1'b0;
      {bi_in, fe_in, pe_in} = 3'b000;
      check_state();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      push = 1'b0; pop = 1'b0; clr = 1'b0; lsr_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      m_ovr = 1'b0;
      m_en  = 1'b0;
      check_state();
   endtask

   initial begin
      vt[0] = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vt[1] = '{1'b1, 8'h41, 3'b001, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1};
      vt[2] = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vt[3] = '{1'b1, 8'h55, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vt[4] = '{1'b1, 8'h12, 3'b100, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0};
      vt[5] = '{1'b1, 8'h34, 3'b000, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0};
      vt[6] = '{1'b1, 8'h56, 3'b010, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h34, 1'b0};
      vt[7] = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h56, 1'b0};
      vt[8] = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vt[9] = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

      en = 1'b1; trig_lvl = 2'b00;
      do_reset();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_trig", 32'(trig), 32'd0);

      // Table vectors: basic push/pop, error tracking, clr priority, empty pop.
      for (int i = 0; i < 10; i++) begin
         step(vt[i].push, vt[i].din, vt[i].errs, vt[i].pop, vt[i].clr, vt[i].lsr);
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_count));
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vt[i].e_empty));
         chk($sformatf("v%0d_trig", i), 32'(trig), 32'(vt[i].e_trig));
         chk($sformatf("v%0d_err", i), 32'(err_in_fifo), 32'(vt[i].e_err));
         chk($sformatf("v%0d_ovr", i), 32'(overrun), 32'(vt[i].e_ovr));
         if (vt[i].chk_d) begin
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vt[i].e_dout));
            chk($sformatf("v%0d_pe", i), 32'(pe_out), 32'(vt[i].e_pe));
         end
      end

      // Fill to full with trigger level 8.
      trig_lvl = 2'b10;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0, 1'b0);
         chk("fill_trig", 32'(trig), 32'(i >= 7));
         chk("fill_full", 32'(full), 32'(i == 15));
      end

      // Overrun on full, then push+pop while full, then LSR read.
      step(1'b1, 8'hAA, 3'b000, 1'b0, 1'b0, 1'b0);
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_head", 32'(dout), 32'h00);
      step(1'b1, 8'hAA, 3'b000, 1'b1, 1'b0, 1'b0);
      chk("pp_count", 32'(count), 32'd16);
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
      chk("ovr_clr", 32'(overrun), 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk("drain_dout", 32'(dout), (i == 15) ? 32'hAA : 32'(i + 1));
         step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // 16450 mode: depth 1, then re-enable flushes but keeps overrun.
      en = 1'b0;
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h11, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 3'b000, 1'b0, 1'b0, 1'b0);
      chk("m0_ovr", 32'(overrun), 32'd1);
      chk("m0_dout", 32'(dout), 32'h11);
      en = 1'b1;
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
      chk("m1_empty", 32'(empty), 32'd1);
      chk("m1_ovr", 32'(overrun), 32'd1);

      // Reset in mid-stream.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 3'b001, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_count", 32'(count), 32'd5);
      do_reset();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h77, 3'b000, 1'b0, 1'b0, 1'b0);
      chk("post_rst_head", 32'(dout), 32'h77);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         if (i % 25 == 0) trig_lvl = 2'($urandom_range(0, 3));
         if (i % 97 == 50) en = ~en;
         step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0), ($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
